// File: rtl/instruction_fetch_unit_pkg.sv
// Shared processor definitions used by the fetch unit: reset PC, FSM encoding,
// PC target selects and opcode constants.
package instruction_fetch_unit_pkg;

    localparam logic [15:0] PC_RESET = 16'h0000;
    localparam logic [15:0] PC_STEP  = 16'h0002;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } ifu_state_e;

    typedef enum logic [1:0] {
        PC_SRC_INC    = 2'b00,
        PC_SRC_BRANCH = 2'b01,
        PC_SRC_JUMP   = 2'b10,
        PC_SRC_RET    = 2'b11
    } pc_src_e;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_LOAD = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_BEQ  = 5'b00100;
    localparam logic [4:0] OP_JMP  = 5'b01000;
    localparam logic [4:0] OP_RET  = 5'b10000;

    // Branch displacement: 11-bit signed immediate in halfwords, as a byte offset.
    function automatic logic [15:0] branch_offset(input logic [10:0] imm);
        return {{4{imm[10]}}, imm, 1'b0};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_next_logic.sv
// Combinational PC target selection; all arithmetic wraps modulo 2^16.
module pc_next_logic
    import instruction_fetch_unit_pkg::*;
(
    input  logic [15:0] pc_i,
    input  logic [10:0] imm_i,
    input  logic [15:0] ret_addr_i,
    input  logic [1:0]  pc_src_i,
    output logic [15:0] target_o
);

    always_comb begin
        target_o = pc_i + PC_STEP;
        case (pc_src_i)
            PC_SRC_INC:    target_o = pc_i + PC_STEP;
            PC_SRC_BRANCH: target_o = pc_i + branch_offset(imm_i);
            PC_SRC_JUMP:   target_o = {pc_i[15:12], imm_i, 1'b0};
            PC_SRC_RET:    target_o = ret_addr_i;
            default:       target_o = pc_i + PC_STEP;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: IDLE/REQ/HOLD handshake with instruction memory,
// owning the PC and the instruction register.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
(
    input  logic        CLK,
    input  logic        Reset,
    input  logic        fetch_req,
    input  logic        decode_ack,
    input  logic        PCWrite,
    input  logic [1:0]  pc_src,
    input  logic [15:0] ret_addr,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid,
    output logic [4:0]  Opcode,
    output logic [10:0] imm,
    output logic        instr_valid,
    output logic [15:0] pc
);

    ifu_state_e  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] fetch_addr_q, fetch_addr_d;
    logic        valid_q, valid_d;
    logic [15:0] pc_target;
    logic        mem_done;

    pc_next_logic u_pc_next (
        .pc_i       (pc_q),
        .imm_i      (ir_q[10:0]),
        .ret_addr_i (ret_addr),
        .pc_src_i   (pc_src),
        .target_o   (pc_target)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (fetch_req) state_d = ST_REQ;
            ST_REQ:  if (mem_valid) state_d = ST_HOLD;
            ST_HOLD: if (decode_ack) state_d = fetch_req ? ST_REQ : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = pc_q;
        if (state_q == ST_REQ) begin
            mem_rd   = 1'b1;
            mem_addr = fetch_addr_q;
        end
    end

    assign mem_done = (state_q == ST_REQ) && mem_valid;

    // Fetch address captures the PC before any same-cycle PCWrite lands.
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        if (state_q != ST_REQ && state_d == ST_REQ) begin
            fetch_addr_d = pc_q;
        end

        ir_d = mem_done ? mem_rdata : ir_q;

        valid_d = valid_q;
        if (mem_done) begin
            valid_d = 1'b1;
        end else if (state_q == ST_HOLD && decode_ack) begin
            valid_d = 1'b0;
        end

        pc_d = pc_q;
        if (PCWrite) begin
            pc_d = pc_target;
        end else if (mem_done) begin
            pc_d = fetch_addr_q + PC_STEP;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q         <= PC_RESET;
            ir_q         <= {OP_NOP, 11'd0};
            fetch_addr_q <= PC_RESET;
            valid_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            fetch_addr_q <= fetch_addr_d;
            valid_q      <= valid_d;
        end
    end

    assign Opcode      = ir_q[15:11];
    assign imm         = ir_q[10:0];
    assign instr_valid = valid_q;
    assign pc          = pc_q;

endmodule
